// File: rtl/osc_trigger_capture.sv
// osc_trigger_capture
//
// Trigger and capture controller between the 8-bit ADC sample stream and the
// circular sample RAM. A capture starts on `arm`. The block first writes a
// pre-trigger history of PRE_TRIG samples, then waits for a level crossing on
// the selected slope, or for an optional auto-trigger timeout. It then writes
// the post-trigger fill and reports the address of the oldest sample so the
// reader can unroll the circular buffer.
//
// Ports:
//   osc_clk          clock; all logic runs on its rising edge
//   reset            synchronous, active-high reset
//   sample_valid     one-cycle strobe marking a new sample
//   sample_data      8-bit unsigned sample value
//   trig_level       trigger threshold; sampled live on every cycle
//   trig_falling     0 = rising crossing, 1 = falling crossing
//   auto_en          enables the auto-trigger timeout
//   arm              pulse that starts a capture (accepted in IDLE and DONE)
//   done_ack         pulse from the reader that releases DONE
//   write_enable     registered RAM write strobe
//   write_address    registered RAM write address
//   write_data       registered RAM write data
//   capture_done     buffer complete and stable
//   trigger_address  address of the trigger sample
//   start_address    address of the oldest sample in the finished buffer
//   triggered_auto   the capture was ended by the timeout, not by a crossing
//   busy             high in PRE_FILL, ARMED and POST_FILL
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for arm; samples are ignored
// PRE_FILL   | writing the PRE_TRIG-sample history; no trigger detection
// ARMED      | writing samples and looking for a crossing or a timeout
// POST_FILL  | writing the DEPTH-PRE_TRIG-1 samples that follow the trigger
// DONE       | buffer stable; hold the result until done_ack or arm

module osc_trigger_capture #(
  parameter int DEPTH        = 25000,
  parameter int ADDR_W       = 16,
  parameter int PRE_TRIG     = 2500,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              osc_clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [7:0]        sample_data,
  input  logic [7:0]        trig_level,
  input  logic              trig_falling,
  input  logic              auto_en,
  input  logic              arm,
  input  logic              done_ack,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        write_data,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trigger_address,
  output logic [ADDR_W-1:0] start_address,
  output logic              triggered_auto,
  output logic              busy
);

  localparam int CNT_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int TO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  PRE_LOAD  = CNT_W'(PRE_TRIG);
  localparam logic [CNT_W-1:0]  POST_LOAD = CNT_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(AUTO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_FILL,
    S_ARMED,
    S_POST_FILL,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] ptr;
  logic [7:0]        prev;
  logic [CNT_W-1:0]  pre_cnt;    // history writes still to go
  logic [CNT_W-1:0]  post_cnt;   // post-trigger writes still to go
  logic [TO_W-1:0]   to_cnt;     // non-triggering ARMED samples left before the forced trigger

  logic arm_accept;
  logic do_write;
  logic crossing;
  logic armed_valid;
  logic hit_cross;
  logic hit_auto;
  logic trig_hit;
  logic pre_last;
  logic post_end;

  // Control decode shared by the FSM and the datapath.
  always_comb begin
    arm_accept  = arm && ((state == S_IDLE) || (state == S_DONE));
    do_write    = sample_valid &&
                  ((state == S_PRE_FILL) || (state == S_ARMED) ||
                   ((state == S_POST_FILL) && (post_cnt != '0)));
    // Threshold equality sits on the crossing side; a sample equal to prev can
    // never satisfy either condition.
    if (trig_falling)
      crossing = (prev > trig_level) && (sample_data <= trig_level);
    else
      crossing = (prev < trig_level) && (sample_data >= trig_level);
    armed_valid = (state == S_ARMED) && sample_valid;
    hit_cross   = armed_valid && crossing;
    hit_auto    = armed_valid && !crossing && auto_en && (to_cnt == '0);
    trig_hit    = hit_cross || hit_auto;
    pre_last    = (state == S_PRE_FILL) && sample_valid && (pre_cnt == CNT_W'(1));
    // DONE is entered one cycle after the final write strobe, so the last RAM
    // write has landed before capture_done rises.
    post_end    = (state == S_POST_FILL) && (post_cnt == '0);
  end

  // State register.
  always_ff @(posedge osc_clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (arm) state_next = S_PRE_FILL;
      S_PRE_FILL:  if (pre_last) state_next = S_ARMED;
      S_ARMED:     if (trig_hit) state_next = S_POST_FILL;
      S_POST_FILL: if (post_end) state_next = S_DONE;
      S_DONE: begin
        if (arm)
          state_next = S_PRE_FILL;
        else if (done_ack)
          state_next = S_IDLE;
      end
      default:     state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy         = 1'b0;
    capture_done = 1'b0;
    case (state)
      S_PRE_FILL, S_ARMED, S_POST_FILL: busy = 1'b1;
      S_DONE:                           capture_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: write port, pointer, counters and the captured result.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      write_enable    <= 1'b0;
      write_address   <= '0;
      write_data      <= '0;
      trigger_address <= '0;
      start_address   <= '0;
      triggered_auto  <= 1'b0;
      ptr             <= '0;
      prev            <= '0;
      pre_cnt         <= '0;
      post_cnt        <= '0;
      to_cnt          <= '0;
    end else begin
      write_enable <= do_write;

      if (do_write) begin
        write_address <= ptr;
        write_data    <= sample_data;
        ptr           <= (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
      end

      if (do_write && ((state == S_PRE_FILL) || (state == S_ARMED)))
        prev <= sample_data;

      if ((state == S_PRE_FILL) && do_write)
        pre_cnt <= pre_cnt - CNT_W'(1);

      // Saturates at zero, so with auto_en low ARMED can wait indefinitely.
      if (armed_valid && !trig_hit && (to_cnt != '0))
        to_cnt <= to_cnt - TO_W'(1);

      if (trig_hit) begin
        trigger_address <= ptr;
        post_cnt        <= POST_LOAD;
        triggered_auto  <= hit_auto;
      end

      if ((state == S_POST_FILL) && do_write)
        post_cnt <= post_cnt - CNT_W'(1);

      // The pointer after the final write is the oldest sample in the buffer.
      if (post_end)
        start_address <= ptr;

      // Never coincides with do_write: arm is only accepted in IDLE and DONE.
      if (arm_accept) begin
        ptr            <= '0;
        pre_cnt        <= PRE_LOAD;
        post_cnt       <= '0;
        to_cnt         <= TO_LOAD;
        triggered_auto <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_osc_trigger_capture.sv
module tb_osc_trigger_capture;

  localparam int DEPTH        = 16;
  localparam int ADDR_W       = 4;
  localparam int PRE_TRIG     = 4;
  localparam int AUTO_TIMEOUT = 8;

  logic              osc_clk = 1'b0;
  logic              reset = 1'b1;
  logic              sample_valid = 1'b0;
  logic [7:0]        sample_data = 8'h00;
  logic [7:0]        trig_level = 8'h00;
  logic              trig_falling = 1'b0;
  logic              auto_en = 1'b0;
  logic              arm = 1'b0;
  logic              done_ack = 1'b0;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [7:0]        write_data;
  logic              capture_done;
  logic [ADDR_W-1:0] trigger_address;
  logic [ADDR_W-1:0] start_address;
  logic              triggered_auto;
  logic              busy;

  osc_trigger_capture #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRE_TRIG(PRE_TRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .osc_clk(osc_clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .trig_level(trig_level),
    .trig_falling(trig_falling),
    .auto_en(auto_en),
    .arm(arm),
    .done_ack(done_ack),
    .write_enable(write_enable),
    .write_address(write_address),
    .write_data(write_data),
    .capture_done(capture_done),
    .trigger_address(trigger_address),
    .start_address(start_address),
    .triggered_auto(triggered_auto),
    .busy(busy)
  );

  always #5 osc_clk = ~osc_clk;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];   // {address, data} of each expected RAM write
  int exp_ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit exp_wr);
    sample_valid = 1'b1;
    sample_data  = d;
    if (exp_wr) begin
      exp_q.push_back({exp_ptr[3:0], d});
      exp_ptr = (exp_ptr + 1) % DEPTH;
    end
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic check_done(input string tag, input int trig, input int start, input int auto_flag);
    chk({tag, "_done_not_early"}, capture_done, 0);
    tick();
    chk({tag, "_capture_done"}, capture_done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_trigger_address"}, trigger_address, trig);
    chk({tag, "_start_address"}, start_address, start);
    chk({tag, "_triggered_auto"}, triggered_auto, auto_flag);
    chk({tag, "_writes_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: every write strobe must match the next expected write.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge osc_clk);
      if (write_enable === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: addr=%0d data=%0h while no write expected",
                   write_address, write_data);
        end else begin
          e = exp_q.pop_front();
          if ({write_address, write_data} !== e) begin
            failures++;
            $display("FAIL write_match: got addr=%0d data=%0h expected addr=%0d data=%0h",
                     write_address, write_data, e[11:8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    // Reset state.
    tick();
    tick();
    chk("rst_write_enable", write_enable, 0);
    chk("rst_write_address", write_address, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_capture_done", capture_done, 0);
    chk("rst_trigger_address", trigger_address, 0);
    chk("rst_start_address", start_address, 0);
    chk("rst_triggered_auto", triggered_auto, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // 1: rising trigger; arm coincides with a sample that must not be written.
    trig_level = 8'h80;
    trig_falling = 1'b0;
    auto_en = 1'b0;
    arm = 1'b1;
    sample_valid = 1'b1;
    sample_data = 8'hEE;
    tick();
    arm = 1'b0;
    sample_valid = 1'b0;
    exp_ptr = 0;
    chk("s1_busy", busy, 1);
    send(8'h10, 1); send(8'h20, 1); send(8'h30, 1); send(8'h40, 1);
    send(8'h50, 1); send(8'h7F, 1); send(8'h80, 1);
    chk("s1_trigger_address_early", trigger_address, 6);
    for (int i = 0; i < 11; i++) send(8'hA0 + 8'(i), 1);
    check_done("s1", 6, 2, 0);
    send(8'h33, 0);

    // 2: falling trigger; arm in DONE restarts at 0, arm in ARMED is ignored.
    trig_falling = 1'b1;
    do_arm();
    for (int i = 0; i < 5; i++) send(8'h90, 1);
    chk("s2_no_trig_equal", trigger_address, 6);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("s2_busy_after_ignored_arm", busy, 1);
    send(8'h81, 1);
    chk("s2_no_trig_above", trigger_address, 6);
    send(8'h80, 1);
    chk("s2_trigger_address", trigger_address, 6);
    for (int i = 0; i < 11; i++) send(8'h70 - 8'(i), 1);
    check_done("s2", 6, 2, 0);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    chk("s2_ack_capture_done", capture_done, 0);
    chk("s2_ack_busy", busy, 0);
    send(8'h55, 0);

    // 3a: auto trigger on the 8th ARMED sample.
    trig_falling = 1'b0;
    auto_en = 1'b1;
    do_arm();
    for (int i = 0; i < 4 + 7; i++) send(8'h20, 1);
    chk("s3_not_yet_forced", trigger_address, 6);
    send(8'h20, 1);
    chk("s3_forced_address", trigger_address, 11);
    for (int i = 0; i < 11; i++) send(8'h20, 1);
    check_done("s3", 11, 7, 1);

    // 3b/4: auto disabled, 100 ARMED samples with gaps and wraps, then a crossing.
    auto_en = 1'b0;
    arm = 1'b1;
    done_ack = 1'b1;
    tick();
    arm = 1'b0;
    done_ack = 1'b0;
    exp_ptr = 0;
    for (int i = 0; i < 4; i++) send(8'h20, 1);
    for (int i = 0; i < 100; i++) begin
      send(8'h20, 1);
      if (i % 3 == 2) tick();
    end
    chk("s4_busy_waiting", busy, 1);
    chk("s4_not_done", capture_done, 0);
    chk("s4_no_trigger", trigger_address, 11);
    send(8'h80, 1);
    chk("s4_trigger_address", trigger_address, 8);
    chk("s4_auto_cleared", triggered_auto, 0);
    for (int i = 0; i < 11; i++) begin
      send(8'h40, 1);
      if (i == 5) tick();
    end
    check_done("s4", 8, 4, 0);

    // 6: reset during POST_FILL.
    do_arm();
    for (int i = 0; i < 4; i++) send(8'h20, 1);
    send(8'h90, 1);
    chk("s6_trigger_address", trigger_address, 4);
    for (int i = 0; i < 3; i++) send(8'h91, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_write_enable", write_enable, 0);
    chk("s6_write_address", write_address, 0);
    chk("s6_write_data", write_data, 0);
    chk("s6_capture_done", capture_done, 0);
    chk("s6_trigger_address_clr", trigger_address, 0);
    chk("s6_start_address", start_address, 0);
    chk("s6_triggered_auto", triggered_auto, 0);
    chk("s6_busy", busy, 0);
    for (int i = 0; i < 5; i++) send(8'hC0, 0);
    tick();
    chk("s6_no_writes_idle", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
